// File: rtl/param_serializer_pkg.sv
// Shared definitions for the servo parameter serial link (serializer and
// deserializer sides): frame geometry, test-pattern header, CRC-8 polynomial
// and the transmit FSM state encoding.
package param_link_pkg;

    localparam int                WORD_W      = 35;
    localparam int                NUM_WORDS   = 12;
    localparam logic [WORD_W-1:0] TP_WORD     = 35'h5_5555_5555;
    localparam int                SYNC_STAGES = 2;

    localparam int                CRC_W       = 8;
    localparam logic [CRC_W-1:0]  CRC_POLY    = 8'h07;

    localparam int                ADDR_W      = 4;
    localparam int                BIT_CNT_W   = $clog2(WORD_W);
    localparam int                WORD_CNT_W  = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        SEND  = 3'd2,
        CRC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One bit of an MSB-first CRC-8 (poly CRC_POLY), shifting din in.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb        = crc[CRC_W-1] ^ din;
        crc8_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/param_serializer_if.sv
// Bus between the parameter source and param_serializer: shadow-bank write
// port, start/busy/done control, and the three serial link wires.
//
// Control handshake: start_in is a one-cycle request that is accepted only
// while busy_out is low; busy_out rises the cycle after acceptance and stays
// high until the frame ends, when done_out pulses for exactly one cycle with
// busy_out already low. Requests seen while busy_out is high are dropped.
interface param_serializer_if;
    import param_link_pkg::*;

    logic              word_we_in;
    logic [ADDR_W-1:0] word_addr_in;
    logic [WORD_W-1:0] word_data_in;
    logic              start_in;
    logic              serial_clk_in;
    logic              serial_trig_in;
    logic              serial_out;
    logic              busy_out;
    logic              done_out;

    // Parameter source / bench side
    modport master (
        output word_we_in, word_addr_in, word_data_in, start_in,
        output serial_clk_in, serial_trig_in,
        input  serial_out, busy_out, done_out
    );

    // Serializer side
    modport slave (
        input  word_we_in, word_addr_in, word_data_in, start_in,
        input  serial_clk_in, serial_trig_in,
        output serial_out, busy_out, done_out
    );

endinterface

// File: rtl/param_serializer_link_edge_sync.sv
// Synchronizer for one asynchronous link wire plus registered rise/fall
// pulses. Input-to-pulse latency is STAGES+1 system clocks.
module link_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Sync chain, delayed copy, and single-cycle edge pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            o_rise <= r_sync[STAGES-1] & ~r_prev;
            o_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

endmodule

// File: rtl/param_serializer.sv
// Transmit side of the servo parameter link. Frames TP_WORD followed by
// NUM_WORDS coefficient words MSB first on serial_out, one bit per falling
// edge of the receiver's link clock, after the receiver's trigger.
// Optional feature macro: PARAM_SER_CRC_EN appends a CRC-8 over the payload.
module param_serializer
    import param_link_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    param_serializer_if.slave   bus,
    output logic [2:0]          o_state_dbg
);

    state_t                r_state;
    state_t                w_state_next;

    logic [WORD_W-1:0]     r_bank  [NUM_WORDS];
    logic [WORD_W-1:0]     r_frame [NUM_WORDS];
    logic [WORD_W-1:0]     r_shift;
    logic                  r_serial;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [WORD_CNT_W-1:0] r_word_cnt;

    logic                  w_clk_rise;
    logic                  w_clk_fall;
    logic                  w_trig_rise;
    logic                  w_trig_fall;
    logic                  w_unused_edges;
    logic                  w_word_end;
    logic                  w_frame_end;
    logic                  w_restart;

`ifdef PARAM_SER_CRC_EN
    logic [CRC_W-1:0]      r_crc;
    logic [CRC_W-1:0]      w_crc_next;
    logic                  w_crc_end;
`endif

    link_edge_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_async (bus.serial_clk_in),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    link_edge_sync #(.STAGES(SYNC_STAGES)) u_trig_sync (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_async (bus.serial_trig_in),
        .o_rise  (w_trig_rise),
        .o_fall  (w_trig_fall)
    );

    // Only the link clock's falling edge and the trigger's rising edge matter.
    assign w_unused_edges = w_clk_rise | w_trig_fall;

    assign w_word_end  = (r_bit_cnt == BIT_CNT_W'(WORD_W - 1));
    assign w_frame_end = w_word_end && (r_word_cnt == WORD_CNT_W'(NUM_WORDS));
    // A trigger edge while a frame is armed or in flight (re)starts it.
    assign w_restart   = w_trig_rise &&
                         ((r_state == ARMED) || (r_state == SEND) || (r_state == CRC));

`ifdef PARAM_SER_CRC_EN
    assign w_crc_next = crc8_step(r_crc, r_serial);
    assign w_crc_end  = (r_bit_cnt == BIT_CNT_W'(CRC_W - 1));
`endif

    assign bus.serial_out = r_serial;
    assign bus.busy_out   = (r_state == ARMED) || (r_state == SEND) || (r_state == CRC);
    assign bus.done_out   = (r_state == DONE);
    assign o_state_dbg    = r_state;

    // Shadow bank: writable at any time, out-of-range addresses dropped
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_WORDS; i++) r_bank[i] <= '0;
        end else if (bus.word_we_in && (bus.word_addr_in < ADDR_W'(NUM_WORDS))) begin
            r_bank[bus.word_addr_in] <= bus.word_data_in;
        end
    end

    // Frame buffer: snapshot of the bank taken when a start is accepted
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_WORDS; i++) r_frame[i] <= '0;
        end else if ((r_state == IDLE) && bus.start_in) begin
            for (int i = 0; i < NUM_WORDS; i++) r_frame[i] <= r_bank[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next-state logic; a trigger edge always takes priority over a clock edge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (bus.start_in) w_state_next = ARMED;
            ARMED: if (w_trig_rise)  w_state_next = SEND;
            SEND: begin
                if (!w_trig_rise && w_clk_fall && w_frame_end) begin
`ifdef PARAM_SER_CRC_EN
                    w_state_next = CRC;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef PARAM_SER_CRC_EN
            CRC: begin
                if (w_trig_rise)                   w_state_next = SEND;
                else if (w_clk_fall && w_crc_end)  w_state_next = DONE;
            end
`endif
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Shift datapath: r_shift[WORD_W-1] is always the bit currently on the wire
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_shift    <= '0;
            r_serial   <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
`ifdef PARAM_SER_CRC_EN
            r_crc      <= '0;
`endif
        end else if (w_restart) begin
            r_shift    <= TP_WORD;
            r_serial   <= TP_WORD[WORD_W-1];
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
`ifdef PARAM_SER_CRC_EN
            r_crc      <= '0;
`endif
        end else if ((r_state == SEND) && w_clk_fall) begin
`ifdef PARAM_SER_CRC_EN
            // Fold in the payload bit being retired; the header is excluded.
            if (r_word_cnt != '0) r_crc <= w_crc_next;
`endif
            if (w_word_end) begin
                r_bit_cnt <= '0;
                if (w_frame_end) begin
                    r_word_cnt <= '0;
`ifdef PARAM_SER_CRC_EN
                    r_serial   <= w_crc_next[CRC_W-1];
`else
                    r_serial   <= 1'b0;
`endif
                end else begin
                    // r_word_cnt indexes the current word with TP at 0, so it
                    // is also the payload index of the next word.
                    r_shift    <= r_frame[r_word_cnt];
                    r_serial   <= r_frame[r_word_cnt][WORD_W-1];
                    r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
                end
            end else begin
                r_shift   <= r_shift << 1;
                r_serial  <= r_shift[WORD_W-2];
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
`ifdef PARAM_SER_CRC_EN
        end else if ((r_state == CRC) && w_clk_fall) begin
            if (w_crc_end) begin
                r_serial  <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                r_crc     <= r_crc << 1;
                r_serial  <= r_crc[CRC_W-2];
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_param_serializer.sv
// Directed testbench for param_serializer: full frames with edge-case words,
// shadow-bank isolation, ignored start while busy, trigger resync mid-frame,
// asynchronous reset mid-frame, and the optional CRC trailer.
`timescale 1ns/1ps
module tb_param_serializer;
    import param_link_pkg::*;

`ifdef PARAM_SER_CRC_EN
    localparam int TAIL_BITS = CRC_W;
`else
    localparam int TAIL_BITS = 0;
`endif
    localparam int FRAME_BITS = (NUM_WORDS + 1) * WORD_W + TAIL_BITS;

    // ---------------- clock / reset ----------------
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [2:0] state_dbg;

    always #5 clk_in = ~clk_in;

    param_serializer_if bus ();

    param_serializer dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .bus         (bus),
        .o_state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int                n_checks = 0;
    int                n_errors = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] model_bank  [NUM_WORDS];
    logic [WORD_W-1:0] model_frame [NUM_WORDS];
    logic              cap [FRAME_BITS];
    int                done_cnt = 0;
    logic              busy_prev = 1'b0;
    logic              done_busy = 1'b1;
    logic              done_busy_prev = 1'b0;

    // Done-pulse monitor, sampled away from the active edge
    always @(negedge clk_in) begin
        if (bus.done_out) begin
            done_cnt       = done_cnt + 1;
            done_busy      = bus.busy_out;
            done_busy_prev = busy_prev;
        end
        busy_prev = bus.busy_out;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data);
        @(negedge clk_in);
        bus.word_we_in   = 1'b1;
        bus.word_addr_in = addr;
        bus.word_data_in = data;
        @(negedge clk_in);
        bus.word_we_in   = 1'b0;
        if (addr < ADDR_W'(NUM_WORDS)) model_bank[addr] = data;
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        bus.start_in = 1'b1;
        @(negedge clk_in);
        bus.start_in = 1'b0;
    endtask

    task automatic trig_edge();
        bus.serial_trig_in = 1'b0;
        repeat (6) @(negedge clk_in);
        bus.serial_trig_in = 1'b1;
        repeat (6) @(negedge clk_in);
    endtask

    // One link clock period; the bit is sampled while the link clock is high.
    task automatic link_bit(output logic b);
        bus.serial_clk_in = 1'b1;
        repeat (5) @(negedge clk_in);
        b = bus.serial_out;
        bus.serial_clk_in = 1'b0;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic capture(input int from, input int to);
        logic b;
        for (int i = from; i < to; i++) begin
            link_bit(b);
            cap[i] = b;
        end
    endtask

    // Reference CRC-8 (poly 0x07, init 0) over the snapshot, MSB first.
    function automatic logic [7:0] crc_ref();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = WORD_W - 1; b >= 0; b--) begin
                fb = c[7] ^ model_frame[w][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic snapshot_and_expect();
        for (int i = 0; i < NUM_WORDS; i++) model_frame[i] = model_bank[i];
        exp_q.push_back(TP_WORD);
        for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back(model_frame[i]);
`ifdef PARAM_SER_CRC_EN
        exp_q.push_back(WORD_W'(crc_ref()));
`endif
    endtask

    task automatic check_frame(input string tag);
        logic [WORD_W-1:0] got;
        logic [WORD_W-1:0] exp;
        for (int w = 0; w < NUM_WORDS + 1; w++) begin
            got = '0;
            for (int b = 0; b < WORD_W; b++) got = {got[WORD_W-2:0], cap[w * WORD_W + b]};
            exp = exp_q.pop_front();
            check_val($sformatf("%s_w%0d", tag, w), 64'(got), 64'(exp));
        end
`ifdef PARAM_SER_CRC_EN
        got = '0;
        for (int b = 0; b < CRC_W; b++) got = {got[WORD_W-2:0], cap[(NUM_WORDS + 1) * WORD_W + b]};
        exp = exp_q.pop_front();
        check_val($sformatf("%s_crc", tag), 64'(got), 64'(exp));
`endif
    endtask

    task automatic check_done(input string tag, input int cnt_before);
        for (int i = 0; i < 30 && done_cnt == cnt_before; i++) @(negedge clk_in);
        repeat (4) @(negedge clk_in);
        check_val({tag, "_done_pulses"}, 64'(done_cnt - cnt_before), 64'd1);
        check_val({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
        check_val({tag, "_busy_before_done"}, 64'(done_busy_prev), 64'd1);
        check_val({tag, "_serial_idle"}, 64'(bus.serial_out), 64'd0);
        check_val({tag, "_state_idle"}, 64'(state_dbg), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    int cnt0;

    initial begin
        bus.word_we_in     = 1'b0;
        bus.word_addr_in   = '0;
        bus.word_data_in   = '0;
        bus.start_in       = 1'b0;
        bus.serial_clk_in  = 1'b0;
        bus.serial_trig_in = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) model_bank[i] = '0;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);

        check_val("rst_serial", 64'(bus.serial_out), 64'd0);
        check_val("rst_busy",   64'(bus.busy_out),   64'd0);
        check_val("rst_done",   64'(bus.done_out),   64'd0);
        check_val("rst_state",  64'(state_dbg),      64'(IDLE));
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Trigger edge while idle does nothing
        trig_edge();
        check_val("idle_trig_serial", 64'(bus.serial_out), 64'd0);
        check_val("idle_trig_busy",   64'(bus.busy_out),   64'd0);

        // Frame 1: word0=1, word11=all ones, out-of-range write ignored
        write_word(4'd0, 35'h1);
        write_word(4'd11, 35'h7_FFFF_FFFF);
        write_word(4'd12, 35'h3_3333_3333);
        pulse_start();
        snapshot_and_expect();
        check_val("f1_busy_armed",   64'(bus.busy_out),   64'd1);
        check_val("f1_state_armed",  64'(state_dbg),      64'(ARMED));
        check_val("f1_serial_armed", 64'(bus.serial_out), 64'd0);
        cnt0 = done_cnt;
        trig_edge();
        check_val("f1_state_send", 64'(state_dbg), 64'(SEND));
        capture(0, FRAME_BITS);
        check_frame("f1");
        check_done("f1", cnt0);

        // Frame 2: coefficient word0, live write to word3 and a start mid-frame
        write_word(4'd0, 35'd24943121);
        pulse_start();
        snapshot_and_expect();
        cnt0 = done_cnt;
        trig_edge();
        capture(0, 100);
        write_word(4'd3, 35'h123);
        pulse_start();
        check_val("f2_busy_after_start", 64'(bus.busy_out), 64'd1);
        capture(100, FRAME_BITS);
        check_frame("f2");
        check_done("f2", cnt0);

        // Frame 3: the earlier write to word3 is now visible
        pulse_start();
        snapshot_and_expect();
        cnt0 = done_cnt;
        trig_edge();
        capture(0, FRAME_BITS);
        check_frame("f3");
        check_done("f3", cnt0);

        // Frame 4: second trigger edge at bit 200 restarts from the header
        pulse_start();
        snapshot_and_expect();
        cnt0 = done_cnt;
        trig_edge();
        capture(0, 200);
        trig_edge();
        check_val("f4_state_resync", 64'(state_dbg), 64'(SEND));
        check_val("f4_resync_msb",   64'(bus.serial_out), 64'(TP_WORD[WORD_W-1]));
        capture(0, FRAME_BITS);
        check_frame("f4");
        check_done("f4", cnt0);

        // Frame 5: reset asserted at bit 100 while a 1 is on the wire
        write_word(4'd1, 35'h7_FFFF_FFFF);
        pulse_start();
        trig_edge();
        capture(0, 100);
        check_val("f5_pre_rst_bit", 64'(bus.serial_out), 64'd1);
        rst_in = 1'b1;
        #1;
        check_val("f5_rst_serial", 64'(bus.serial_out), 64'd0);
        check_val("f5_rst_busy",   64'(bus.busy_out),   64'd0);
        check_val("f5_rst_state",  64'(state_dbg),      64'(IDLE));
        for (int i = 0; i < NUM_WORDS; i++) model_bank[i] = '0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (6) @(negedge clk_in);

        // Frame 6: after reset the bank is all zero and a new frame completes
        pulse_start();
        snapshot_and_expect();
        cnt0 = done_cnt;
        trig_edge();
        capture(0, FRAME_BITS);
        check_frame("f6");
        check_done("f6", cnt0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
